// File: rtl/lcd_spi_seq.sv
// rtl/lcd_spi_seq.sv - ST7789-class panel init/fill sequencer with integrated SPI mode-0 byte shifter
module lcd_spi_seq #(
   parameter int CLK_DIV   = 4,
   parameter int H_RES     = 240,
   parameter int V_RES     = 320,
   parameter int BPP_BYTES = 2,
   parameter int SLP_WAIT  = 120000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        init_req,
   input  logic        fill_req,
   input  logic [8:0]  x0,
   input  logic [8:0]  x1,
   input  logic [8:0]  y0,
   input  logic [8:0]  y1,
   input  logic [23:0] color,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        cs,
   output logic        scl,
   output logic        sda,
   output logic        dc
);

   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP     = 2 * CLK_DIV;
   localparam int CNT_MAX = (SLP_WAIT > GAP) ? SLP_WAIT : GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] SLP_LAST   = CNT_W'(SLP_WAIT - 1);
   localparam logic [9:0]       H_LIM      = 10'(H_RES);
   localparam logic [9:0]       V_LIM      = 10'(V_RES);
   localparam logic [7:0]       COLMOD_ARG = (BPP_BYTES == 3) ? 8'h66 : 8'h55;
   localparam logic [5:0]       PIX_SH0    = 6'(8 * (3 - BPP_BYTES));
   localparam logic [2:0]       PIX_LAST   = 3'(BPP_BYTES - 1);

   typedef enum logic [3:0] {
      IDLE, SWRESET, WAIT1, SLPOUT, WAIT2, COLMOD, DISPON,
      CASET, RASET, RAMWR, PIXELS, FINISH
   } state_t;

   typedef enum logic [1:0] {PH_GAP, PH_SEND, PH_WAIT} phase_t;

   state_t             state_q, state_d;
   phase_t             ph_q, ph_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         idx_q, idx_d;
   logic [17:0]        pix_q, pix_d;
   logic               cs_q, cs_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               init_q, init_d;
   logic [8:0]         x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
   logic [23:0]        color_q, color_d;

   logic               sh_busy_q, sh_busy_d;
   logic [6:0]         sh_rest_q, sh_rest_d;
   logic [2:0]         sh_bit_q, sh_bit_d;
   logic [DIV_W-1:0]   sh_div_q, sh_div_d;
   logic               scl_q, scl_d, sda_q, sda_d, dc_q, dc_d;

   logic               tx_start;
   logic [7:0]         cur_byte;
   logic               cur_dc;
   logic [2:0]         grp_last;
   logic [23:0]        pix_shift;
   logic [9:0]         win_w, win_h;
   logic [17:0]        win_n;
   logic               win_bad;

   // Window geometry; widths are 10 bits so the +1 of a full-width window cannot wrap.
   always_comb begin
      win_w   = {1'b0, x1} - {1'b0, x0} + 10'd1;
      win_h   = {1'b0, y1} - {1'b0, y0} + 10'd1;
      win_n   = {8'b0, win_w} * {8'b0, win_h};
      win_bad = (x1 < x0) || (y1 < y0) || ({1'b0, x1} >= H_LIM) || ({1'b0, y1} >= V_LIM);
   end

   // Byte to send for the current state and position within its group.
   always_comb begin
      pix_shift = color_q << (PIX_SH0 + {idx_q, 3'b000});
      cur_byte  = 8'h00;
      cur_dc    = 1'b1;
      grp_last  = 3'd0;
      case (state_q)
         SWRESET: begin cur_byte = 8'h01; cur_dc = 1'b0; end
         SLPOUT:  begin cur_byte = 8'h11; cur_dc = 1'b0; end
         COLMOD: begin
            grp_last = 3'd1;
            cur_byte = (idx_q == 3'd0) ? 8'h3A : COLMOD_ARG;
            cur_dc   = (idx_q != 3'd0);
         end
         DISPON:  begin cur_byte = 8'h29; cur_dc = 1'b0; end
         CASET: begin
            grp_last = 3'd4;
            case (idx_q)
               3'd0:    begin cur_byte = 8'h2A; cur_dc = 1'b0; end
               3'd1:    cur_byte = {7'b0, x0_q[8]};
               3'd2:    cur_byte = x0_q[7:0];
               3'd3:    cur_byte = {7'b0, x1_q[8]};
               default: cur_byte = x1_q[7:0];
            endcase
         end
         RASET: begin
            grp_last = 3'd4;
            case (idx_q)
               3'd0:    begin cur_byte = 8'h2B; cur_dc = 1'b0; end
               3'd1:    cur_byte = {7'b0, y0_q[8]};
               3'd2:    cur_byte = y0_q[7:0];
               3'd3:    cur_byte = {7'b0, y1_q[8]};
               default: cur_byte = y1_q[7:0];
            endcase
         end
         RAMWR:   begin cur_byte = 8'h2C; cur_dc = 1'b0; end
         PIXELS: begin
            grp_last = PIX_LAST;
            cur_byte = pix_shift[23:16];
         end
         default: ;
      endcase
   end

   // Sequencer: every command state runs GAP (cs high) -> SEND -> WAIT per byte of its group.
   always_comb begin
      state_d  = state_q;
      ph_d     = ph_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      pix_d    = pix_q;
      cs_d     = cs_q;
      ready_d  = ready_q;
      err_d    = 1'b0;
      init_d   = init_q;
      x0_d     = x0_q;
      x1_d     = x1_q;
      y0_d     = y0_q;
      y1_d     = y1_q;
      color_d  = color_q;
      tx_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (init_req) begin
               state_d = SWRESET;
               ph_d    = PH_GAP;
               cnt_d   = '0;
               ready_d = 1'b0;
               init_d  = 1'b1;
            end else if (fill_req && ready_q) begin
               if (win_bad) begin
                  err_d = 1'b1;
               end else begin
                  x0_d    = x0;
                  x1_d    = x1;
                  y0_d    = y0;
                  y1_d    = y1;
                  color_d = color;
                  pix_d   = win_n;
                  state_d = CASET;
                  ph_d    = PH_GAP;
                  cnt_d   = '0;
                  init_d  = 1'b0;
               end
            end
         end
         WAIT1: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SLP_LAST) begin
               cnt_d   = '0;
               state_d = SLPOUT;
               ph_d    = PH_GAP;
            end
         end
         WAIT2: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SLP_LAST) begin
               cnt_d   = '0;
               state_d = COLMOD;
               ph_d    = PH_GAP;
            end
         end
         FINISH: begin
            state_d = IDLE;
            if (init_q) ready_d = 1'b1;
         end
         default: begin
            case (ph_q)
               PH_GAP: begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == GAP_LAST) begin
                     cnt_d = '0;
                     cs_d  = 1'b0;
                     idx_d = '0;
                     ph_d  = PH_SEND;
                  end
               end
               PH_SEND: begin
                  tx_start = 1'b1;
                  ph_d     = PH_WAIT;
               end
               default: if (!sh_busy_q) begin
                  if (idx_q != grp_last) begin
                     idx_d = idx_q + 3'd1;
                     ph_d  = PH_SEND;
                  end else begin
                     idx_d = '0;
                     ph_d  = PH_GAP;
                     cs_d  = 1'b1;
                     case (state_q)
                        SWRESET: state_d = WAIT1;
                        SLPOUT:  state_d = WAIT2;
                        COLMOD:  state_d = DISPON;
                        DISPON:  state_d = FINISH;
                        CASET:   state_d = RASET;
                        RASET:   state_d = RAMWR;
                        RAMWR: begin
                           // Pixels follow RAMWR inside the same cs-low group.
                           state_d = PIXELS;
                           ph_d    = PH_SEND;
                           cs_d    = 1'b0;
                        end
                        PIXELS: begin
                           if (pix_q > 18'd1) begin
                              pix_d = pix_q - 18'd1;
                              ph_d  = PH_SEND;
                              cs_d  = 1'b0;
                           end else begin
                              state_d = FINISH;
                           end
                        end
                        default: state_d = IDLE;
                     endcase
                  end
               end
            endcase
         end
      endcase
      busy_d = (state_d != IDLE) && (state_d != FINISH);
      done_d = (state_d == FINISH);
   end

   // Mode-0 shifter: sda moves only on scl falling, so it is stable across each rising edge.
   always_comb begin
      sh_busy_d = sh_busy_q;
      sh_rest_d = sh_rest_q;
      sh_bit_d  = sh_bit_q;
      sh_div_d  = sh_div_q;
      scl_d     = scl_q;
      sda_d     = sda_q;
      dc_d      = dc_q;
      if (!sh_busy_q) begin
         if (tx_start) begin
            sh_busy_d = 1'b1;
            sh_rest_d = cur_byte[6:0];
            sh_bit_d  = 3'd7;
            sh_div_d  = '0;
            scl_d     = 1'b0;
            sda_d     = cur_byte[7];
            dc_d      = cur_dc;
         end
      end else if (sh_div_q == DIV_LAST) begin
         sh_div_d = '0;
         if (!scl_q) begin
            scl_d = 1'b1;
         end else begin
            scl_d = 1'b0;
            if (sh_bit_q == 3'd0) begin
               sh_busy_d = 1'b0;
            end else begin
               sh_bit_d  = sh_bit_q - 3'd1;
               sda_d     = sh_rest_q[6];
               sh_rest_d = {sh_rest_q[5:0], 1'b0};
            end
         end
      end else begin
         sh_div_d = sh_div_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ph_q      <= PH_GAP;
         cnt_q     <= '0;
         idx_q     <= '0;
         pix_q     <= '0;
         cs_q      <= 1'b1;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         init_q    <= 1'b0;
         x0_q      <= '0;
         x1_q      <= '0;
         y0_q      <= '0;
         y1_q      <= '0;
         color_q   <= '0;
         sh_busy_q <= 1'b0;
         sh_rest_q <= '0;
         sh_bit_q  <= '0;
         sh_div_q  <= '0;
         scl_q     <= 1'b0;
         sda_q     <= 1'b0;
         dc_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         pix_q     <= pix_d;
         cs_q      <= cs_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         init_q    <= init_d;
         x0_q      <= x0_d;
         x1_q      <= x1_d;
         y0_q      <= y0_d;
         y1_q      <= y1_d;
         color_q   <= color_d;
         sh_busy_q <= sh_busy_d;
         sh_rest_q <= sh_rest_d;
         sh_bit_q  <= sh_bit_d;
         sh_div_q  <= sh_div_d;
         scl_q     <= scl_d;
         sda_q     <= sda_d;
         dc_q      <= dc_d;
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;
   assign cs    = cs_q;
   assign scl   = scl_q;
   assign sda   = sda_q;
   assign dc    = dc_q;

endmodule
